risc_toy_mem_arbiter: RTL and testbench
=======================================

# risc_toy_mem_arbiter

Single-port memory arbiter for the RISC_TOY core. It shares one synchronous memory port between the IF-stage instruction fetch requester and the MEM-stage load/store requester. Grants are issued in the request cycle, and read data returns one cycle later. Data accesses win by default; a starvation counter guarantees fetch progress. Sits between the pipeline and the external memory, replacing the separate IREQ/DREQ paths.

## Interface
- AW, 30: word-address width
- DW, 32: data width
- STARVE_MAX, 4: max consecutive denied cycles for a pending fetch before fetch is forced (≥1)
- CLK  in  1  clock, rising edge
- RSTN  in  1  reset, asynchronous, active-low
- I_REQ  in  1  fetch request
- I_ADDR  in  AW  fetch word address
- I_GNT  out  1  fetch granted this cycle
- I_VALID  out  1  fetch data valid
- I_RDATA  out  DW  fetch data
- FLUSH  in  1  taken branch/jump: cancel fetch traffic
- D_REQ  in  1  data request
- D_RW  in  1  1 = write, 0 = read
- D_ADDR  in  AW  data word address
- D_WDATA  in  DW  store data
- D_GNT  out  1  data granted this cycle
- D_VALID  out  1  data response (read data or write ack)
- D_RDATA  out  DW  load data
- M_REQ  out  1  memory request
- M_RW  out  1  1 = write
- M_ADDR  out  AW  memory address
- M_WDATA  out  DW  memory write data
- M_RDATA  in  DW  memory read data, valid the cycle after an accepted read

## Operation
- Effective fetch request: ireq_e = I_REQ & ~FLUSH.
- Arbitration, combinational each cycle:
  - Both requests present and starve_cnt < STARVE_MAX: data wins.
  - Both requests present and starve_cnt == STARVE_MAX: fetch wins.
  - Single requester: that requester wins.
  - At most one of I_GNT/D_GNT is high.
- M_REQ = I_GNT | D_GNT. Memory-side signals are muxed from the winner:
  - Fetch: M_RW=0, M_ADDR=I_ADDR.
  - Data: M_RW=D_RW, M_ADDR=D_ADDR, M_WDATA=D_WDATA.
  - Idle: M_ADDR/M_WDATA are 0.
- starve_cnt, width clog2(STARVE_MAX+1):
  - Clears when I_GNT or ~ireq_e.
  - Increments when ireq_e & ~I_GNT.
  - Saturates at STARVE_MAX.
- Response tracker (registered state):
  - States: IDLE, RSP_I, RSP_D.
  - Next state = RSP_I if I_GNT, RSP_D if D_GNT, else IDLE.
  - Back-to-back grants overlap: a new grant in the response cycle is legal.
- Fetch response:
  - I_VALID = (state==RSP_I) & ~FLUSH.
  - I_RDATA = M_RDATA when I_VALID, else i_hold.
  - i_hold captures M_RDATA on I_VALID.
- Data response:
  - D_VALID = (state==RSP_D), for both reads and writes.
  - D_RDATA = M_RDATA on a read response, else d_hold.
  - A write response leaves d_hold unchanged. This requires a registered rw bit.
- FLUSH never affects data traffic.

## Timing
- Reset values:
  - All outputs 0.
  - state=IDLE, starve_cnt=0, i_hold=0, d_hold=0.
- Grant latency: 0 cycles (combinational from REQ). Response latency: exactly 1 cycle after grant. Throughput: 1 access/cycle.
- Requesters hold REQ/ADDR/WDATA until they see GNT. The arbiter stores no request.
- FLUSH in cycle t:
  - Suppresses I_GNT in t.
  - Suppresses I_VALID for a fetch granted in t-1.
  - i_hold is unchanged.
  - starve_cnt clears.
- Reset asserted mid-access drops any pending response. No VALID appears after RSTN rises until a new grant.
- Worst-case fetch wait with continuous data requests: STARVE_MAX cycles, with the grant in cycle STARVE_MAX+1.

## Test plan
- Reset: hold RSTN low with both REQs high → every output 0; after release, first grant goes to D.
- Lone fetch: I_REQ=1, I_ADDR=0x10 at t; M_RDATA=0xDEADBEEF at t+1 → I_GNT at t with M_ADDR=0x10, M_RW=0; I_VALID=1 and I_RDATA=0xDEADBEEF at t+1; I_RDATA stays 0xDEADBEEF after.
- Starvation (STARVE_MAX=4): I_REQ and D_REQ held high for 6 cycles → grant order D,D,D,D,I,D; starve_cnt sequence 1,2,3,4,0,1.
- Store: D_RW=1, D_ADDR=0x20, D_WDATA=0x1234 → same cycle M_REQ=1, M_RW=1, M_WDATA=0x1234; D_VALID=1 at t+1; D_RDATA unchanged.
- Flush: fetch granted at t, FLUSH=1 at t+1 with I_REQ=1 and a pending D read → I_VALID=0 and no I_GNT at t+1; D_GNT=1 at t+1; I_RDATA holds its prior value.
- Reset mid-op: D read granted at t, RSTN low during t+1 → D_VALID=0; after release, outputs stay 0 until the next request.

Source files
------------

// File: rtl/risc_toy_mem_arbiter_if.sv
// Bundle of fetch, data and memory-port signals around the RISC_TOY memory arbiter.
// slave is the arbiter's view; master is the pipeline plus memory side.
interface risc_toy_mem_arbiter_if #(
   parameter int AW = 30,
   parameter int DW = 32
);
   logic          I_REQ;
   logic [AW-1:0] I_ADDR;
   logic          I_GNT;
   logic          I_VALID;
   logic [DW-1:0] I_RDATA;
   logic          FLUSH;

   logic          D_REQ;
   logic          D_RW;
   logic [AW-1:0] D_ADDR;
   logic [DW-1:0] D_WDATA;
   logic          D_GNT;
   logic          D_VALID;
   logic [DW-1:0] D_RDATA;

   logic          M_REQ;
   logic          M_RW;
   logic [AW-1:0] M_ADDR;
   logic [DW-1:0] M_WDATA;
   logic [DW-1:0] M_RDATA;

   modport slave (
      input  I_REQ, I_ADDR, FLUSH,
      input  D_REQ, D_RW, D_ADDR, D_WDATA,
      input  M_RDATA,
      output I_GNT, I_VALID, I_RDATA,
      output D_GNT, D_VALID, D_RDATA,
      output M_REQ, M_RW, M_ADDR, M_WDATA
   );

   modport master (
      output I_REQ, I_ADDR, FLUSH,
      output D_REQ, D_RW, D_ADDR, D_WDATA,
      output M_RDATA,
      input  I_GNT, I_VALID, I_RDATA,
      input  D_GNT, D_VALID, D_RDATA,
      input  M_REQ, M_RW, M_ADDR, M_WDATA
   );
endinterface

// File: rtl/risc_toy_mem_arbiter.sv
// Shares one synchronous memory port between instruction fetch and load/store.
// Data wins by default; a saturating starvation counter forces fetch progress.
module risc_toy_mem_arbiter #(
   parameter int AW         = 30,
   parameter int DW         = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic                 CLK,
   input  logic                 RSTN,
   risc_toy_mem_arbiter_if.slave bus
);

   localparam int            CW         = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

   typedef enum logic [1:0] {IDLE, RSP_I, RSP_D} rsp_state_t;

   rsp_state_t    state;
   logic          d_rw_q;
   logic [CW-1:0] starve_cnt;
   logic [DW-1:0] i_hold;
   logic [DW-1:0] d_hold;

   logic          ireq_e;
   logic          fetch_forced;
   logic          i_win;
   logic          d_win;
   logic          i_valid;
   logic          d_valid;
   logic          d_rd_rsp;
   logic [AW-1:0] m_addr_n;
   logic [DW-1:0] m_wdata_n;

   // Grants are gated by RSTN so every output reads 0 while reset is held.
   always_comb begin
      ireq_e       = bus.I_REQ & ~bus.FLUSH;
      fetch_forced = (starve_cnt == STARVE_LIM);
      i_win        = RSTN & ireq_e & (~bus.D_REQ | fetch_forced);
      d_win        = RSTN & bus.D_REQ & ~(ireq_e & fetch_forced);

      i_valid      = (state == RSP_I) & ~bus.FLUSH;
      d_valid      = (state == RSP_D);
      d_rd_rsp     = d_valid & ~d_rw_q;

      m_addr_n  = '0;
      m_wdata_n = '0;
      if (i_win) begin
         m_addr_n = bus.I_ADDR;
      end else if (d_win) begin
         m_addr_n  = bus.D_ADDR;
         m_wdata_n = bus.D_WDATA;
      end
   end

   always_comb begin
      bus.I_GNT   = i_win;
      bus.D_GNT   = d_win;
      bus.M_REQ   = i_win | d_win;
      bus.M_RW    = d_win & bus.D_RW;
      bus.M_ADDR  = m_addr_n;
      bus.M_WDATA = m_wdata_n;
      bus.I_VALID = i_valid;
      bus.I_RDATA = i_valid ? bus.M_RDATA : i_hold;
      bus.D_VALID = d_valid;
      bus.D_RDATA = d_rd_rsp ? bus.M_RDATA : d_hold;
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state      <= IDLE;
         d_rw_q     <= 1'b0;
         starve_cnt <= '0;
         i_hold     <= '0;
         d_hold     <= '0;
      end else begin
         if (i_win)
            state <= RSP_I;
         else if (d_win)
            state <= RSP_D;
         else
            state <= IDLE;

         // Remembered so a write ack leaves the load-data hold register alone.
         d_rw_q <= d_win & bus.D_RW;

         if (i_win | ~ireq_e)
            starve_cnt <= '0;
         else if (starve_cnt != STARVE_LIM)
            starve_cnt <= starve_cnt + CW'(1);

         if (i_valid)
            i_hold <= bus.M_RDATA;
         if (d_rd_rsp)
            d_hold <= bus.M_RDATA;
      end
   end

endmodule

// File: tb/tb_risc_toy_mem_arbiter.sv
// Directed bench for risc_toy_mem_arbiter: grants checked inline, responses
// checked by a monitor against a queue of expected read data.
module tb_risc_toy_mem_arbiter;
   localparam int AW = 30;
   localparam int DW = 32;
   localparam int SM = 4;

   logic CLK  = 1'b0;
   logic RSTN = 1'b0;
   always #5 CLK = ~CLK;

   risc_toy_mem_arbiter_if #(.AW(AW), .DW(DW)) bus();

   risc_toy_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
      .CLK  (CLK),
      .RSTN (RSTN),
      .bus  (bus)
   );

   int tests = 0;
   int fails = 0;
   logic [DW-1:0] iq[$];
   logic [DW-1:0] dq[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic ireq, input logic [AW-1:0] iaddr, input logic flush,
                        input logic dreq, input logic drw, input logic [AW-1:0] daddr,
                        input logic [DW-1:0] wdata, input logic [DW-1:0] mrdata);
      bus.I_REQ   = ireq;
      bus.I_ADDR  = iaddr;
      bus.FLUSH   = flush;
      bus.D_REQ   = dreq;
      bus.D_RW    = drw;
      bus.D_ADDR  = daddr;
      bus.D_WDATA = wdata;
      bus.M_RDATA = mrdata;
   endtask

   task automatic next_cycle();
      @(posedge CLK);
      #1;
   endtask

   // Response monitor: every VALID must match the oldest expected entry.
   initial begin
      forever begin
         @(negedge CLK);
         if (bus.I_VALID === 1'b1) begin
            if (iq.size() == 0) chk("i_valid_unexpected", bus.I_VALID, 0);
            else                chk("i_rdata", bus.I_RDATA, iq.pop_front());
         end
         if (bus.D_VALID === 1'b1) begin
            if (dq.size() == 0) chk("d_valid_unexpected", bus.D_VALID, 0);
            else                chk("d_rdata", bus.D_RDATA, dq.pop_front());
         end
      end
   end

   initial begin
      logic exp_i;

      // Reset held with both requesters active: everything must read 0.
      drive(1, 30'h40, 0, 1, 0, 30'h80, 32'h99, 32'h0);
      @(negedge CLK);
      chk("rst_i_gnt",   bus.I_GNT, 0);
      chk("rst_d_gnt",   bus.D_GNT, 0);
      chk("rst_m_req",   bus.M_REQ, 0);
      chk("rst_m_rw",    bus.M_RW, 0);
      chk("rst_m_addr",  bus.M_ADDR, 0);
      chk("rst_m_wdata", bus.M_WDATA, 0);
      chk("rst_i_valid", bus.I_VALID, 0);
      chk("rst_d_valid", bus.D_VALID, 0);
      chk("rst_i_rdata", bus.I_RDATA, 0);
      chk("rst_d_rdata", bus.D_RDATA, 0);
      next_cycle();
      RSTN = 1'b1;

      // Starvation: both held for 6 cycles -> D,D,D,D,I,D.
      for (int i = 0; i < 6; i++) begin
         drive(1, 30'h40, 0, 1, 0, 30'h80, 32'h99, 32'h5100_0000 + i);
         @(negedge CLK);
         exp_i = (i == 4);
         chk($sformatf("starve%0d_i_gnt", i), bus.I_GNT, exp_i);
         chk($sformatf("starve%0d_d_gnt", i), bus.D_GNT, !exp_i);
         chk($sformatf("starve%0d_m_addr", i), bus.M_ADDR, exp_i ? 30'h40 : 30'h80);
         if (exp_i) iq.push_back(32'h5100_0000 + i + 1);
         else       dq.push_back(32'h5100_0000 + i + 1);
         next_cycle();
      end
      drive(0, 0, 0, 0, 0, 0, 0, 32'h5100_0006);
      @(negedge CLK);
      chk("idle_m_req",  bus.M_REQ, 0);
      chk("idle_m_addr", bus.M_ADDR, 0);
      next_cycle();

      // Lone fetch.
      drive(1, 30'h10, 0, 0, 0, 0, 0, 32'h0BAD_F00D);
      @(negedge CLK);
      chk("fetch_i_gnt",  bus.I_GNT, 1);
      chk("fetch_d_gnt",  bus.D_GNT, 0);
      chk("fetch_m_req",  bus.M_REQ, 1);
      chk("fetch_m_addr", bus.M_ADDR, 30'h10);
      chk("fetch_m_rw",   bus.M_RW, 0);
      chk("fetch_i_hold_prev", bus.I_RDATA, 32'h5100_0005);
      iq.push_back(32'hDEAD_BEEF);
      next_cycle();
      drive(0, 0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF);
      @(negedge CLK);
      chk("fetch_i_valid", bus.I_VALID, 1);
      next_cycle();
      drive(0, 0, 0, 0, 0, 0, 0, 32'h0BAD_F00D);
      @(negedge CLK);
      chk("fetch_i_valid_after", bus.I_VALID, 0);
      chk("fetch_i_rdata_hold",  bus.I_RDATA, 32'hDEAD_BEEF);
      next_cycle();

      // Store: write ack keeps the previous load data.
      drive(0, 0, 0, 1, 1, 30'h20, 32'h1234, 32'h1357_9BDF);
      @(negedge CLK);
      chk("store_d_gnt",   bus.D_GNT, 1);
      chk("store_m_req",   bus.M_REQ, 1);
      chk("store_m_rw",    bus.M_RW, 1);
      chk("store_m_addr",  bus.M_ADDR, 30'h20);
      chk("store_m_wdata", bus.M_WDATA, 32'h1234);
      dq.push_back(32'h5100_0006);
      next_cycle();
      drive(0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF);
      @(negedge CLK);
      chk("store_d_valid", bus.D_VALID, 1);
      next_cycle();
      drive(0, 0, 0, 0, 0, 0, 0, 32'h0);
      @(negedge CLK);
      chk("store_d_valid_after", bus.D_VALID, 0);
      chk("store_d_rdata_hold",  bus.D_RDATA, 32'h5100_0006);
      next_cycle();

      // Flush kills the in-flight fetch; data traffic is untouched.
      drive(1, 30'h30, 0, 0, 0, 0, 0, 32'h0);
      @(negedge CLK);
      chk("flush_pre_i_gnt",  bus.I_GNT, 1);
      chk("flush_pre_m_addr", bus.M_ADDR, 30'h30);
      next_cycle();
      drive(1, 30'h30, 1, 1, 0, 30'h24, 0, 32'h7777_7777);
      @(negedge CLK);
      chk("flush_i_valid", bus.I_VALID, 0);
      chk("flush_i_gnt",   bus.I_GNT, 0);
      chk("flush_d_gnt",   bus.D_GNT, 1);
      chk("flush_m_addr",  bus.M_ADDR, 30'h24);
      chk("flush_i_rdata", bus.I_RDATA, 32'hDEAD_BEEF);
      dq.push_back(32'h2222_2222);
      next_cycle();
      drive(0, 0, 1, 0, 0, 0, 0, 32'h2222_2222);
      @(negedge CLK);
      chk("flush_d_valid", bus.D_VALID, 1);
      chk("flush_i_rdata2", bus.I_RDATA, 32'hDEAD_BEEF);
      next_cycle();
      drive(0, 0, 0, 0, 0, 0, 0, 32'h0);
      @(negedge CLK);
      chk("flush_i_rdata3", bus.I_RDATA, 32'hDEAD_BEEF);
      chk("flush_i_valid3", bus.I_VALID, 0);
      next_cycle();

      // A flushed cycle clears the starvation count: 3 denials, flush, then 4 more D.
      for (int k = 0; k < 9; k++) begin
         drive(1, 30'h44, (k == 3), 1, 0, 30'h84, 0, 32'h6200_0000 + k);
         @(negedge CLK);
         exp_i = (k == 8);
         chk($sformatf("fstarve%0d_i_gnt", k), bus.I_GNT, exp_i);
         chk($sformatf("fstarve%0d_d_gnt", k), bus.D_GNT, !exp_i);
         if (exp_i) iq.push_back(32'h6200_0000 + k + 1);
         else       dq.push_back(32'h6200_0000 + k + 1);
         next_cycle();
      end
      drive(0, 0, 0, 0, 0, 0, 0, 32'h6200_0009);
      @(negedge CLK);
      next_cycle();

      // Reset asserted during a pending read response drops it.
      drive(0, 0, 0, 1, 0, 30'h28, 0, 32'h0);
      @(negedge CLK);
      chk("rmid_d_gnt", bus.D_GNT, 1);
      next_cycle();
      RSTN = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 32'hAAAA_AAAA);
      @(negedge CLK);
      chk("rmid_d_valid", bus.D_VALID, 0);
      chk("rmid_d_rdata", bus.D_RDATA, 0);
      chk("rmid_i_rdata", bus.I_RDATA, 0);
      chk("rmid_m_req",   bus.M_REQ, 0);
      next_cycle();
      RSTN = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge CLK);
         chk($sformatf("rpost%0d_d_valid", k), bus.D_VALID, 0);
         chk($sformatf("rpost%0d_i_valid", k), bus.I_VALID, 0);
         chk($sformatf("rpost%0d_d_rdata", k), bus.D_RDATA, 0);
         next_cycle();
      end

      // Service resumes after reset.
      drive(1, 30'h3C, 0, 0, 0, 0, 0, 32'h0);
      @(negedge CLK);
      chk("resume_i_gnt",  bus.I_GNT, 1);
      chk("resume_m_addr", bus.M_ADDR, 30'h3C);
      iq.push_back(32'hCAFE_F00D);
      next_cycle();
      drive(0, 0, 0, 0, 0, 0, 0, 32'hCAFE_F00D);
      @(negedge CLK);
      chk("resume_i_valid", bus.I_VALID, 1);
      next_cycle();
      drive(0, 0, 0, 0, 0, 0, 0, 32'h0);
      repeat (2) @(negedge CLK);

      chk("iq_drained", iq.size(), 0);
      chk("dq_drained", dq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
